score_sequencer: RTL and testbench
==================================

SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 Parameter NUM_NOTES, default 16, notes per song (1..255).
REQ-002 Parameter CMP_LATENCY, default 4, cycles from cmp_start to valid cmp_score (1..15).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  global run enable; low freezes the block.
REQ-006 song_start  in  1  one-cycle pulse; begins a scoring pass.
REQ-007 note_addr  out  8  reference note ROM address.
REQ-008 ref_freq_in  in  15  ROM data (Hz), valid 1 cycle after note_addr changes.
REQ-009 sung_valid  in  1  one-cycle strobe from pitch detector.
REQ-010 sung_freq_in  in  15  detected sung frequency (Hz), qualified by sung_valid.
REQ-011 cmp_start  out  1  start pulse to comparison unit.
REQ-012 cmp_sung_freq, cmp_ref_freq  out  15 each  operands to comparison unit.
REQ-013 cmp_score  in  4  comparison result, 0..10.
REQ-014 total_score  out  12  running sum of note scores.
REQ-015 notes_scored  out  8  notes counted into total_score.
REQ-016 busy  out  1  high from accepted song_start until done.
REQ-017 done  out  1  one-cycle pulse when pass completes.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT_SUNG, COMPARE, WAIT_SCORE, ACCUM, DONE.
REQ-019 IDLE: on song_start -> FETCH; note_addr, total_score, notes_scored cleared to 0 in same edge.
REQ-020 FETCH: one cycle wait for ROM; latch ref_freq_in on exit; -> WAIT_SUNG.
REQ-021 Latched ref_freq = 0 (rest): no comparison, no count; go directly to ACCUM with score contribution 0, notes_scored unchanged.
REQ-022 WAIT_SUNG: on sung_valid latch sung_freq_in; sung_freq_in = 0 (silence) -> ACCUM, contributes 0, counts as scored; else -> COMPARE.
REQ-023 COMPARE: cmp_start high exactly one cycle, cmp_sung_freq/cmp_ref_freq driven from latches and held stable until ACCUM exits.
REQ-024 WAIT_SCORE: count CMP_LATENCY cycles after cmp_start, sample cmp_score on final count; -> ACCUM.
REQ-025 Sampled cmp_score > 10 clamped to 10.
REQ-026 ACCUM: total_score += score, notes_scored += 1 (except rest); if note_addr = NUM_NOTES-1 -> DONE else note_addr+1, -> FETCH.
REQ-027 DONE: done high one cycle, busy low from next cycle; total_score, notes_scored held until next accepted song_start; -> IDLE.
REQ-028 busy high in all states except IDLE; low in DONE cycle's successor.
REQ-029 song_start while busy ignored; sung_valid outside WAIT_SUNG ignored (no buffering).
REQ-030 enable low: state, counters, latches held; cmp_start forced low; WAIT_SCORE counter paused; a song_start or sung_valid in a disabled cycle is ignored.
REQ-031 total_score width sufficient without overflow (10 x 255 = 2550); no wrap.
REQ-032 sung_valid and enable rising in same cycle: strobe accepted.

Reset
REQ-033 rst_n low: state IDLE; note_addr, total_score, notes_scored, latches, wait counter = 0; cmp_start, busy, done = 0.
REQ-034 Reset mid-pass aborts immediately; no done pulse; outputs cleared.

Structure
REQ-035 Shared scoring package holds FREQ_W = 15, SCORE_W = 4, MAX_NOTE_SCORE = 10, FSM state encoding.
REQ-036 comparison unit instantiated outside this block; no sub-modules beyond an optional latency counter score_wait_timer.

Verification
REQ-037 NUM_NOTES=2, refs 440,440; sung 880 then 466, model scores 10,7 -> total_score=17, notes_scored=2, one done pulse.
REQ-038 Ref 0 (rest) at note 0, ref 440 at note 1, sung 440 -> no cmp_start for note 0, total_score=10, notes_scored=1.
REQ-039 Sung 0 for a note -> no cmp_start, contribution 0, notes_scored incremented.
REQ-040 cmp_start to score sample spacing = CMP_LATENCY (4 and 7 tested); model returning 13 -> contribution 10.
REQ-041 enable low 3 cycles during WAIT_SCORE and sung_valid during COMPARE -> completion delayed 3 cycles, stray strobe ignored, totals unchanged.
REQ-042 rst_n low during WAIT_SCORE -> all outputs 0, no done; new song_start runs clean pass.

Source files
------------

// File: rtl/score_sequencer_pkg.sv
// Shared scoring types and constants for the note-scoring sequencer.
package score_sequencer_pkg;

   localparam int FREQ_W         = 15;
   localparam int SCORE_W        = 4;
   localparam int MAX_NOTE_SCORE = 10;
   localparam int ADDR_W         = 8;
   localparam int TOTAL_W        = 12;
   localparam int TIMER_W        = 4;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH      = 3'd1,
      ST_WAIT_SUNG  = 3'd2,
      ST_COMPARE    = 3'd3,
      ST_WAIT_SCORE = 3'd4,
      ST_ACCUM      = 3'd5,
      ST_DONE       = 3'd6
   } seq_state_t;

   // A misbehaving comparison unit must never push a note above full marks.
   function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] raw);
      return (raw > SCORE_W'(MAX_NOTE_SCORE)) ? SCORE_W'(MAX_NOTE_SCORE) : raw;
   endfunction

endpackage

// File: rtl/score_wait_timer.sv
// Down-counter that measures the comparison-unit latency; terminal count at zero.
module score_wait_timer
   import score_sequencer_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic tc
);

   logic [TIMER_W-1:0] cnt_q;

   // Load on the cmp_start cycle so the final count lands LATENCY cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= TIMER_W'(LATENCY - 1);
      end else if (run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - TIMER_W'(1);
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/score_sequencer.sv
// Walks the reference note ROM, pairs each note with a sung pitch, and sums the scores.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | waiting for song_start
// FETCH       | ROM read in flight; reference latched on exit
// WAIT_SUNG   | waiting for the pitch-detector strobe
// COMPARE     | one-cycle cmp_start to the comparison unit
// WAIT_SCORE  | counting comparison latency, sample score on terminal count
// ACCUM       | add contribution, advance to next note or finish
// DONE        | one-cycle completion pulse
module score_sequencer
   import score_sequencer_pkg::*;
#(
   parameter int NUM_NOTES   = 16,
   parameter int CMP_LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               song_start,
   output logic [ADDR_W-1:0]  note_addr,
   input  logic [FREQ_W-1:0]  ref_freq_in,
   input  logic               sung_valid,
   input  logic [FREQ_W-1:0]  sung_freq_in,
   output logic               cmp_start,
   output logic [FREQ_W-1:0]  cmp_sung_freq,
   output logic [FREQ_W-1:0]  cmp_ref_freq,
   input  logic [SCORE_W-1:0] cmp_score,
   output logic [TOTAL_W-1:0] total_score,
   output logic [ADDR_W-1:0]  notes_scored,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);

   seq_state_t          state_q;
   seq_state_t          state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   notes_q;
   logic [TOTAL_W-1:0]  total_q;
   logic [FREQ_W-1:0]   ref_q;
   logic [FREQ_W-1:0]   sung_q;
   logic [SCORE_W-1:0]  contrib_q;
   logic                count_q;
   logic                timer_tc;

   score_wait_timer #(
      .LATENCY (CMP_LATENCY)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (enable && (state_q == ST_COMPARE)),
      .run   (enable && (state_q == ST_WAIT_SCORE)),
      .tc    (timer_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a low enable parks the machine where it is.
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            ST_IDLE:       if (song_start) state_d = ST_FETCH;
            ST_FETCH:      state_d = (ref_freq_in == '0) ? ST_ACCUM : ST_WAIT_SUNG;
            ST_WAIT_SUNG:  if (sung_valid) state_d = (sung_freq_in == '0) ? ST_ACCUM : ST_COMPARE;
            ST_COMPARE:    state_d = ST_WAIT_SCORE;
            ST_WAIT_SCORE: if (timer_tc) state_d = ST_ACCUM;
            ST_ACCUM:      state_d = (addr_q == LAST_ADDR) ? ST_DONE : ST_FETCH;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
         endcase
      end
   end

   // Status and handshake outputs decoded from state.
   always_comb begin
      cmp_start = enable && (state_q == ST_COMPARE);
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
   end

   // Datapath: address, operand latches, per-note contribution and running totals.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         notes_q   <= '0;
         total_q   <= '0;
         ref_q     <= '0;
         sung_q    <= '0;
         contrib_q <= '0;
         count_q   <= 1'b0;
      end else if (enable) begin
         case (state_q)
            ST_IDLE: begin
               if (song_start) begin
                  addr_q  <= '0;
                  notes_q <= '0;
                  total_q <= '0;
               end
            end
            ST_FETCH: begin
               ref_q <= ref_freq_in;
               if (ref_freq_in == '0) begin
                  contrib_q <= '0;
                  count_q   <= 1'b0;
               end
            end
            ST_WAIT_SUNG: begin
               if (sung_valid) begin
                  sung_q <= sung_freq_in;
                  if (sung_freq_in == '0) begin
                     contrib_q <= '0;
                     count_q   <= 1'b1;
                  end
               end
            end
            ST_WAIT_SCORE: begin
               if (timer_tc) begin
                  contrib_q <= clamp_score(cmp_score);
                  count_q   <= 1'b1;
               end
            end
            ST_ACCUM: begin
               total_q <= total_q + TOTAL_W'(contrib_q);
               if (count_q) notes_q <= notes_q + ADDR_W'(1);
               if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign note_addr     = addr_q;
   assign notes_scored  = notes_q;
   assign total_score   = total_q;
   assign cmp_ref_freq  = ref_q;
   assign cmp_sung_freq = sung_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: two instances (latency 4 and 7), a ROM model,
// a comparison-unit model and a per-song reference of the expected totals.
module tb_score_sequencer;

   localparam int LAT_A = 4;
   localparam int LAT_B = 7;
   localparam int NN_A  = 2;
   localparam int NN_B  = 5;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n        [2];
   logic        enable       [2];
   logic        song_start   [2];
   logic        sung_valid   [2];
   logic [14:0] sung_freq_in [2];
   logic [14:0] ref_freq_in  [2];
   logic [7:0]  note_addr    [2];
   logic        cmp_start    [2];
   logic [14:0] cmp_sung_freq[2];
   logic [14:0] cmp_ref_freq [2];
   logic [3:0]  cmp_score    [2];
   logic [11:0] total_score  [2];
   logic [7:0]  notes_scored [2];
   logic        busy         [2];
   logic        done         [2];

   score_sequencer #(.NUM_NOTES(NN_A), .CMP_LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .song_start(song_start[0]),
      .note_addr(note_addr[0]), .ref_freq_in(ref_freq_in[0]),
      .sung_valid(sung_valid[0]), .sung_freq_in(sung_freq_in[0]),
      .cmp_start(cmp_start[0]), .cmp_sung_freq(cmp_sung_freq[0]), .cmp_ref_freq(cmp_ref_freq[0]),
      .cmp_score(cmp_score[0]), .total_score(total_score[0]), .notes_scored(notes_scored[0]),
      .busy(busy[0]), .done(done[0]));

   score_sequencer #(.NUM_NOTES(NN_B), .CMP_LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .song_start(song_start[1]),
      .note_addr(note_addr[1]), .ref_freq_in(ref_freq_in[1]),
      .sung_valid(sung_valid[1]), .sung_freq_in(sung_freq_in[1]),
      .cmp_start(cmp_start[1]), .cmp_sung_freq(cmp_sung_freq[1]), .cmp_ref_freq(cmp_ref_freq[1]),
      .cmp_score(cmp_score[1]), .total_score(total_score[1]), .notes_scored(notes_scored[1]),
      .busy(busy[1]), .done(done[1]));

   int checks = 0;
   int errors = 0;
   int cyc_ctr = 0;

   // song tables: reference ROM, what the singer produces, what the comparator answers
   logic [14:0] ref_tbl  [2][256];
   logic [14:0] sung_tbl [2][256];
   int          sc_tbl   [2][256];

   // expectations of the comparison model, in cmp_start order
   int sc_q [2][$];
   int rf_q [2][$];
   int sg_q [2][$];

   int exp_total, exp_notes, exp_cmps;
   int done_cnt   [2] = '{0, 0};
   int cmp_starts [2] = '{0, 0};
   bit act        [2] = '{0, 0};
   int rem        [2] = '{0, 0};
   int cur_sc     [2] = '{0, 0};
   int cur_rf     [2] = '{0, 0};
   int cur_sg     [2] = '{0, 0};

   always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

   // ROM: data follows the address combinationally, well inside the FETCH cycle
   always_comb begin
      ref_freq_in[0] = ref_tbl[0][note_addr[0]];
      ref_freq_in[1] = ref_tbl[1][note_addr[1]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lat(input int k);
      return (k == 0) ? LAT_A : LAT_B;
   endfunction

   // Comparison unit: score is valid only in the cycle the latency has elapsed
   // (counting enabled cycles only), zero otherwise.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n[k]) begin
            act[k]       = 1'b0;
            cmp_score[k] = 4'd0;
         end else begin
            if (done[k]) done_cnt[k]++;
            if (act[k] && rem[k] == 0) begin
               cmp_score[k] = 4'(cur_sc[k]);
               check("cmp_ref_stable", 32'(cmp_ref_freq[k]), cur_rf[k]);
               check("cmp_sung_stable", 32'(cmp_sung_freq[k]), cur_sg[k]);
            end else begin
               cmp_score[k] = 4'd0;
            end
            if (cmp_start[k]) begin
               cmp_starts[k]++;
               if (sc_q[k].size() > 0) begin
                  cur_sc[k] = sc_q[k].pop_front();
                  cur_rf[k] = rf_q[k].pop_front();
                  cur_sg[k] = sg_q[k].pop_front();
               end else begin
                  cur_sc[k] = 0;
               end
               check("cmp_ref_at_start", 32'(cmp_ref_freq[k]), cur_rf[k]);
               check("cmp_sung_at_start", 32'(cmp_sung_freq[k]), cur_sg[k]);
               rem[k] = lat(k) - 1;
               act[k] = 1'b1;
            end else if (act[k] && enable[k]) begin
               if (rem[k] == 0) act[k] = 1'b0;
               else rem[k]--;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: rests add nothing and are not counted; silence is counted at 0;
   // anything else is counted at the comparator score capped at 10.
   task automatic load_song(input int k, input int n);
      exp_total = 0; exp_notes = 0; exp_cmps = 0;
      for (int i = 0; i < n; i++) begin
         if (ref_tbl[k][i] == 0) continue;
         exp_notes++;
         if (sung_tbl[k][i] == 0) continue;
         exp_cmps++;
         exp_total += (sc_tbl[k][i] > 10) ? 10 : sc_tbl[k][i];
         sc_q[k].push_back(sc_tbl[k][i]);
         rf_q[k].push_back(int'(ref_tbl[k][i]));
         sg_q[k].push_back(int'(sung_tbl[k][i]));
      end
   endtask

   task automatic check_idle(input int k);
      check("idle_note_addr", note_addr[k], 0);
      check("idle_total", total_score[k], 0);
      check("idle_notes", notes_scored[k], 0);
      check("idle_busy", busy[k], 0);
      check("idle_done", done[k], 0);
      check("idle_cmp_start", cmp_start[k], 0);
      check("idle_cmp_ref", cmp_ref_freq[k], 0);
      check("idle_cmp_sung", cmp_sung_freq[k], 0);
   endtask

   task automatic run_song(input int k, input int n, input bit rnd_gap, input int disrupt,
                           input bit stray_start, input int glitch, output int cyc);
      int t0, dc0, cs0, wait_n, d;
      load_song(k, n);
      dc0 = done_cnt[k];
      cs0 = cmp_starts[k];
      song_start[k] = 1'b1;
      step();
      song_start[k] = 1'b0;
      t0 = cyc_ctr;
      check("busy_after_start", busy[k], 1);
      check("addr_cleared", note_addr[k], 0);
      check("total_cleared", total_score[k], 0);
      check("notes_cleared", notes_scored[k], 0);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            wait_n = 0;
            while (note_addr[k] != 8'(i) && wait_n < 60) begin
               step();
               wait_n++;
            end
            check("next_note_addr", note_addr[k], i);
         end
         // in FETCH of note i
         song_start[k] = stray_start && (i == 1);
         step();
         song_start[k] = 1'b0;
         if (ref_tbl[k][i] == 0) continue;
         d = rnd_gap ? int'($urandom_range(0, 2)) : 0;
         repeat (d) step();
         if (i == glitch) begin
            enable[k] = 1'b0;
            sung_valid[k] = 1'b1;
            sung_freq_in[k] = 15'd77;
            step();
            sung_valid[k] = 1'b0;
            step();
            enable[k] = 1'b1;
         end
         sung_valid[k] = 1'b1;
         sung_freq_in[k] = sung_tbl[k][i];
         step();
         sung_valid[k] = 1'b0;
         sung_freq_in[k] = 15'($urandom_range(1, 32767));
         if (i == disrupt && sung_tbl[k][i] != 0) begin
            sung_valid[k] = 1'b1;
            sung_freq_in[k] = 15'd123;
            step();
            sung_valid[k] = 1'b0;
            step();
            enable[k] = 1'b0;
            repeat (3) step();
            enable[k] = 1'b1;
         end
      end
      wait_n = 0;
      while (done[k] !== 1'b1 && wait_n < 100) begin
         step();
         wait_n++;
      end
      check("done_seen", done[k], 1);
      cyc = cyc_ctr - t0;
      check("total_at_done", total_score[k], exp_total);
      check("notes_at_done", notes_scored[k], exp_notes);
      step();
      check("done_one_cycle", done[k], 0);
      check("busy_low_after_done", busy[k], 0);
      check("total_held", total_score[k], exp_total);
      check("notes_held", notes_scored[k], exp_notes);
      check("done_pulses", done_cnt[k] - dc0, 1);
      check("cmp_start_count", cmp_starts[k] - cs0, exp_cmps);
   endtask

   initial begin
      int cyc_a, cyc_b, dc0, wait_n;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; enable[k] = 1'b1; song_start[k] = 1'b0;
         sung_valid[k] = 1'b0; sung_freq_in[k] = 15'd0;
         for (int i = 0; i < 256; i++) begin
            ref_tbl[k][i] = 15'd0; sung_tbl[k][i] = 15'd0; sc_tbl[k][i] = 0;
         end
      end
      repeat (3) step();
      check_idle(0);
      check_idle(1);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      step();

      // two sung notes scored 10 and 7
      ref_tbl[0][0] = 15'd440; ref_tbl[0][1] = 15'd440;
      sung_tbl[0][0] = 15'd880; sung_tbl[0][1] = 15'd466;
      sc_tbl[0][0] = 10; sc_tbl[0][1] = 7;
      run_song(0, 2, 0, -1, 0, -1, cyc_a);
      check("basic_total", total_score[0], 17);
      check("pass_len_lat4", cyc_a, 2 * (4 + LAT_A));

      // rest at note 0, stray song_start mid-pass
      ref_tbl[0][0] = 15'd0; ref_tbl[0][1] = 15'd440;
      sung_tbl[0][1] = 15'd440; sc_tbl[0][1] = 10;
      run_song(0, 2, 1, -1, 1, -1, cyc_a);
      check("rest_total", total_score[0], 10);
      check("rest_notes", notes_scored[0], 1);

      // silence at note 0, clamp of 13 at note 1, strobe in a disabled cycle
      ref_tbl[0][0] = 15'd440; sung_tbl[0][0] = 15'd0;
      sung_tbl[0][1] = 15'd500; sc_tbl[0][1] = 13;
      run_song(0, 2, 0, -1, 0, 1, cyc_a);
      check("silence_clamp_total", total_score[0], 10);
      check("silence_clamp_notes", notes_scored[0], 2);

      // freeze during WAIT_SCORE delays completion by exactly the frozen cycles
      sung_tbl[0][0] = 15'd440; sung_tbl[0][1] = 15'd440;
      sc_tbl[0][0] = 5; sc_tbl[0][1] = 6;
      run_song(0, 2, 0, -1, 0, -1, cyc_a);
      run_song(0, 2, 0, 1, 0, -1, cyc_b);
      check("freeze_delay", cyc_b - cyc_a, 3);
      check("freeze_total", total_score[0], 11);

      // latency 7 pass length
      for (int i = 0; i < NN_B; i++) begin
         ref_tbl[1][i] = 15'(300 + 10 * i);
         sung_tbl[1][i] = 15'(310 + 10 * i);
         sc_tbl[1][i] = int'($urandom_range(0, 15));
      end
      run_song(1, NN_B, 0, -1, 0, -1, cyc_a);
      check("pass_len_lat7", cyc_a, NN_B * (4 + LAT_B));

      // random songs
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < NN_B; i++) begin
            ref_tbl[1][i]  = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(50, 4000));
            sung_tbl[1][i] = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom_range(50, 4000));
            sc_tbl[1][i]   = int'($urandom_range(0, 15));
         end
         run_song(1, NN_B, 1, -1, bit'($urandom_range(0, 1)), -1, cyc_a);
      end

      // reset in WAIT_SCORE of the second note aborts the pass
      ref_tbl[0][0] = 15'd440; ref_tbl[0][1] = 15'd440;
      sung_tbl[0][0] = 15'd500; sung_tbl[0][1] = 15'd600;
      sc_tbl[0][0] = 9; sc_tbl[0][1] = 3;
      load_song(0, 2);
      dc0 = done_cnt[0];
      song_start[0] = 1'b1; step(); song_start[0] = 1'b0;
      step();
      sung_valid[0] = 1'b1; sung_freq_in[0] = 15'd500; step(); sung_valid[0] = 1'b0;
      wait_n = 0;
      while (note_addr[0] != 8'd1 && wait_n < 40) begin step(); wait_n++; end
      step();
      sung_valid[0] = 1'b1; sung_freq_in[0] = 15'd600; step(); sung_valid[0] = 1'b0;
      step();
      step();
      check("pre_reset_total", total_score[0], 9);
      rst_n[0] = 1'b0;
      #1;
      check_idle(0);
      repeat (2) step();
      rst_n[0] = 1'b1;
      sc_q[0].delete(); rf_q[0].delete(); sg_q[0].delete();
      repeat (10) step();
      check("no_done_after_abort", done_cnt[0] - dc0, 0);
      run_song(0, 2, 0, -1, 0, -1, cyc_a);
      check("clean_after_reset_total", total_score[0], 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
